// File: rtl/tl_mem_responder_pkg.sv
// TL-UL memory responder shared types, widths and opcodes.
// Defines the Channel D response entry carried through the response FIFO.
package tl_mem_responder_pkg;

    localparam int TL_ADDR_BITS   = 32;
    localparam int TL_DATA_BYTES  = 8;
    localparam int TL_DATA_BITS   = TL_DATA_BYTES * 8;
    localparam int TL_SIZE_BITS   = 3;
    localparam int TL_SOURCE_BITS = 8;
    localparam int TL_SINK_BITS   = 2;
    localparam int TL_OFF_BITS    = $clog2(TL_DATA_BYTES);

    localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
    localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;
    localparam logic [2:0] TL_A_GET        = 3'd4;

    localparam logic [3:0] TL_D_ACCESSACK     = 4'd0;
    localparam logic [3:0] TL_D_ACCESSACKDATA = 4'd1;

    typedef struct packed {
        logic [3:0]                opcode;
        logic [TL_SIZE_BITS-1:0]   size;
        logic [TL_SOURCE_BITS-1:0] source;
        logic                      denied;
        logic [TL_DATA_BITS-1:0]   data;
    } tl_d_entry_t;

    localparam int TL_D_ENTRY_BITS = $bits(tl_d_entry_t);

    // True when the low address bits are zero for a 2^size transfer.
    function automatic logic tl_is_aligned(
        input logic [TL_OFF_BITS-1:0]  lo,
        input logic [TL_SIZE_BITS-1:0] size
    );
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < TL_OFF_BITS; i++) begin
            if (i < int'(size) && lo[i]) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/tl_mem_responder_fifo.sv
// tl_resp_fifo: synchronous FIFO with count/full/empty, async active-low reset.
// Ports: push/push_data in, pop/pop_data out (zero when empty), count, full, empty.
module tl_resp_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 2,
    parameter int CNT_BITS = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [WIDTH-1:0]    push_data,
    input  logic                pop,
    output logic [WIDTH-1:0]    pop_data,
    output logic [CNT_BITS-1:0] count,
    output logic                full,
    output logic                empty
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    store [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                do_push;
    logic                do_pop;

    function automatic logic [PTR_BITS-1:0] ptr_next(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count == CNT_BITS'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= ptr_next(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_next(rd_ptr);
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/tl_mem_responder.sv
// TL-UL slave: Get/PutFull/PutPartial on a byte-maskable word memory.
// Ports: Channel A in (a_*), Channel D out (d_*) via response FIFO, denied_count.
module tl_mem_responder
    import tl_mem_responder_pkg::*;
#(
    parameter int                      MEM_WORDS  = 256,
    parameter logic [TL_ADDR_BITS-1:0] BASE_ADDR  = '0,
    parameter int                      RESP_DEPTH = 2,
    parameter logic [TL_SINK_BITS-1:0] SINK_ID    = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_valid,
    output logic                      a_ready,
    input  logic [2:0]                a_opcode,
    input  logic [2:0]                a_param,
    input  logic [TL_SIZE_BITS-1:0]   a_size,
    input  logic [TL_SOURCE_BITS-1:0] a_source,
    input  logic [TL_ADDR_BITS-1:0]   a_address,
    input  logic [TL_DATA_BYTES-1:0]  a_mask,
    input  logic [TL_DATA_BITS-1:0]   a_data,
    output logic                      d_valid,
    input  logic                      d_ready,
    output logic [3:0]                d_opcode,
    output logic [1:0]                d_param,
    output logic [TL_SIZE_BITS-1:0]   d_size,
    output logic [TL_SOURCE_BITS-1:0] d_source,
    output logic [TL_SINK_BITS-1:0]   d_sink,
    output logic                      d_denied,
    output logic [TL_DATA_BITS-1:0]   d_data,
    output logic [7:0]                denied_count
);

    localparam int IDX_BITS = $clog2(MEM_WORDS);
    localparam int CNT_BITS = $clog2(RESP_DEPTH + 1);
    localparam logic [TL_ADDR_BITS:0] WIN_BYTES =
        (TL_ADDR_BITS + 1)'(MEM_WORDS * TL_DATA_BYTES);

    logic [TL_DATA_BITS-1:0] mem [MEM_WORDS];

    logic                    rdy_q;
    logic [CNT_BITS-1:0]     fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    tl_d_entry_t             push_entry;
    tl_d_entry_t             head;

    logic [TL_ADDR_BITS-1:0] offset;
    logic [TL_ADDR_BITS-1:0] word_addr;
    logic [IDX_BITS-1:0]     idx;
    logic                    op_ok;
    logic                    in_range;
    logic                    denied;
    logic                    is_get;
    logic                    fire;
    logic                    unused_bits;

    // rdy_q keeps A closed until the first clock after reset release.
    assign a_ready = rdy_q && (fifo_count < CNT_BITS'(RESP_DEPTH));
    assign fire    = a_valid && a_ready;

    assign offset    = a_address - BASE_ADDR;
    assign word_addr = offset >> TL_OFF_BITS;
    assign idx       = word_addr[IDX_BITS-1:0];
    assign in_range  = (a_address >= BASE_ADDR) && ({1'b0, offset} < WIN_BYTES);

    assign op_ok  = (a_opcode == TL_A_PUTFULL) ||
                    (a_opcode == TL_A_PUTPARTIAL) ||
                    (a_opcode == TL_A_GET);
    assign is_get = (a_opcode == TL_A_GET);
    assign denied = !op_ok ||
                    (a_size > TL_SIZE_BITS'(TL_OFF_BITS)) ||
                    !tl_is_aligned(a_address[TL_OFF_BITS-1:0], a_size) ||
                    !in_range;

    always_comb begin
        push_entry        = '0;
        push_entry.opcode = is_get ? TL_D_ACCESSACKDATA : TL_D_ACCESSACK;
        push_entry.size   = a_size;
        push_entry.source = a_source;
        push_entry.denied = denied;
        if (is_get && !denied) push_entry.data = mem[idx];
    end

    // Memory is intentionally left unreset.
    always_ff @(posedge clk) begin
        if (fire && !denied && !is_get) begin
            for (int i = 0; i < TL_DATA_BYTES; i++) begin
                if (a_mask[i]) mem[idx][8*i +: 8] <= a_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q        <= 1'b0;
            denied_count <= '0;
        end else begin
            rdy_q <= 1'b1;
            if (fire && denied && denied_count != 8'hFF) begin
                denied_count <= denied_count + 8'd1;
            end
        end
    end

    tl_resp_fifo #(
        .WIDTH (TL_D_ENTRY_BITS),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data (push_entry),
        .pop       (d_valid && d_ready),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign d_valid  = !fifo_empty;
    assign d_opcode = head.opcode;
    assign d_param  = 2'd0;
    assign d_size   = head.size;
    assign d_source = head.source;
    assign d_sink   = SINK_ID;
    assign d_denied = head.denied;
    assign d_data   = head.data;

    assign unused_bits = ^{a_param, word_addr, fifo_full};

endmodule

// File: tb/tb_tl_mem_responder.sv
// Self-checking bench for tl_mem_responder: directed steps plus random traffic.
// A queue-based reference model predicts every Channel D response.
module tb_tl_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [2:0]  a_opcode = '0;
    logic [2:0]  a_param = '0;
    logic [2:0]  a_size = '0;
    logic [7:0]  a_source = '0;
    logic [31:0] a_address = '0;
    logic [7:0]  a_mask = '0;
    logic [63:0] a_data = '0;
    logic        d_valid;
    logic        d_ready = 1'b1;
    logic [3:0]  d_opcode;
    logic [1:0]  d_param;
    logic [2:0]  d_size;
    logic [7:0]  d_source;
    logic [1:0]  d_sink;
    logic        d_denied;
    logic [63:0] d_data;
    logic [7:0]  denied_count;

    tl_mem_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_opcode     (a_opcode),
        .a_param      (a_param),
        .a_size       (a_size),
        .a_source     (a_source),
        .a_address    (a_address),
        .a_mask       (a_mask),
        .a_data       (a_data),
        .d_valid      (d_valid),
        .d_ready      (d_ready),
        .d_opcode     (d_opcode),
        .d_param      (d_param),
        .d_size       (d_size),
        .d_source     (d_source),
        .d_sink       (d_sink),
        .d_denied     (d_denied),
        .d_data       (d_data),
        .denied_count (denied_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  size;
        logic [7:0]  src;
        logic        den;
        logic [63:0] data;
    } resp_t;

    logic [63:0] mdl [256];
    resp_t       q [$];
    int          dcnt = 0;
    bit          rdy_en = 0;
    bit          last_acc = 0;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one accepted request, from the protocol rules.
    task automatic model_accept();
        logic [31:0] ad;
        int          sz;
        int          op;
        int          w;
        bit          den;
        resp_t       r;
        ad  = a_address;
        sz  = int'(a_size);
        op  = int'(a_opcode);
        den = !(op == 0 || op == 1 || op == 4) || sz > 3 ||
              (ad % (32'd1 << sz)) != 0 || ad >= 32'd2048;
        w   = int'(ad / 8);
        r.op   = (op == 4) ? 4'd1 : 4'd0;
        r.size = a_size;
        r.src  = a_source;
        r.den  = den;
        r.data = '0;
        if (!den) begin
            if (op == 4) r.data = mdl[w];
            else begin
                for (int i = 0; i < 8; i++) begin
                    if (a_mask[i]) mdl[w][8*i +: 8] = a_data[8*i +: 8];
                end
            end
        end
        if (den && dcnt < 255) dcnt++;
        q.push_back(r);
    endtask

    task automatic cycle();
        bit acc;
        bit pop;
        @(negedge clk);
        chk("a_ready", a_ready, rdy_en && q.size() < 2);
        chk("d_valid", d_valid, q.size() > 0);
        chk("denied_count", denied_count, dcnt);
        if (q.size() > 0) begin
            chk("d_opcode", d_opcode, q[0].op);
            chk("d_size", d_size, q[0].size);
            chk("d_source", d_source, q[0].src);
            chk("d_denied", d_denied, q[0].den);
            chk("d_data", d_data, q[0].data);
            chk("d_param", d_param, 0);
            chk("d_sink", d_sink, 0);
        end
        acc = a_valid && rdy_en && q.size() < 2;
        pop = q.size() > 0 && d_ready;
        if (pop) void'(q.pop_front());
        if (acc) model_accept();
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] src,
                        input logic [31:0] ad, input logic [7:0] m, input logic [63:0] dt);
        a_opcode  = op;
        a_size    = sz;
        a_source  = src;
        a_address = ad;
        a_mask    = m;
        a_data    = dt;
        a_valid   = 1'b1;
        last_acc  = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (last_acc) break;
        end
        chk("accept_within_bound", last_acc, 1);
        a_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        a_valid = 1'b0;
        #1;
        q.delete();
        dcnt   = 0;
        rdy_en = 0;
        chk("rst_d_valid", d_valid, 0);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_denied_count", denied_count, 0);
        chk("rst_d_opcode", d_opcode, 0);
        chk("rst_d_source", d_source, 0);
        chk("rst_d_size", d_size, 0);
        chk("rst_d_denied", d_denied, 0);
        chk("rst_d_data", d_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        rdy_en = 1;
    endtask

    task automatic rand_req();
        int          r;
        logic [2:0]  op;
        logic [2:0]  sz;
        logic [31:0] ad;
        r  = int'($urandom % 16);
        op = (r < 5) ? 3'd4 : (r < 9) ? 3'd0 : (r < 13) ? 3'd1 : 3'($urandom % 8);
        sz = ($urandom % 8 == 0) ? 3'($urandom % 8) : 3'($urandom % 4);
        if ($urandom % 6 == 0) ad = $urandom % 32'h1000;
        else ad = ($urandom % 256) * 8 + (($urandom % 8) & ~((32'd1 << sz) - 1));
        a_opcode  = op;
        a_size    = sz;
        a_address = ad;
        a_mask    = 8'($urandom);
        a_data    = {$urandom, $urandom};
        a_source  = 8'($urandom);
        a_param   = 3'($urandom);
        a_valid   = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        d_ready = 1'b1;
        send(3'd0, 3'd3, 8'd5, 32'h10, 8'hFF, 64'h1122334455667788);
        cycle();
        send(3'd4, 3'd3, 8'd6, 32'h10, 8'h00, 64'h0);
        #2 chk("putfull_get_word", d_data, 64'h1122334455667788);
        cycle();
        send(3'd1, 3'd3, 8'd7, 32'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB);
        send(3'd4, 3'd3, 8'd8, 32'h10, 8'h00, 64'h0);
        #2 chk("putpartial_get_word", d_data, 64'h11223344_BBBBBBBB);
        cycle();
        cycle();

        for (int w = 0; w < 256; w++) begin
            send(3'd0, 3'd3, 8'(w), 32'(w * 8), 8'hFF, {$urandom, $urandom});
        end
        cycle();

        send(3'd4, 3'd3, 8'd9, 32'h800, 8'hFF, 64'h0);
        send(3'd4, 3'd3, 8'd10, 32'h4, 8'hFF, 64'h0);
        cycle();
        cycle();
        chk("denied_count_two", denied_count, 2);

        send(3'd2, 3'd3, 8'd11, 32'h18, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        send(3'd4, 3'd3, 8'd12, 32'h18, 8'h00, 64'h0);
        cycle();
        cycle();

        d_ready = 1'b0;
        send(3'd4, 3'd3, 8'd1, 32'h10, 8'h00, 64'h0);
        send(3'd4, 3'd3, 8'd2, 32'h18, 8'h00, 64'h0);
        #2 chk("bp_head_source", d_source, 1);
        a_opcode  = 3'd4;
        a_size    = 3'd3;
        a_source  = 8'd3;
        a_address = 32'h20;
        a_valid   = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        d_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (last_acc) a_valid = 1'b0;
        end
        chk("bp_third_taken", a_valid, 0);

        for (int i = 0; i < 8; i++) begin
            send(3'd4, 3'd3, 8'(20 + i), 32'(i * 8), 8'h00, 64'h0);
        end
        cycle();
        cycle();

        d_ready = 1'b0;
        send(3'd4, 3'd3, 8'd40, 32'h30, 8'h00, 64'h0);
        send(3'd4, 3'd3, 8'd41, 32'h38, 8'h00, 64'h0);
        do_reset();
        d_ready = 1'b1;
        send(3'd4, 3'd3, 8'd42, 32'h10, 8'h00, 64'h0);
        cycle();

        last_acc = 0;
        a_valid  = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (!a_valid || last_acc) begin
                if ($urandom % 4 != 0) rand_req();
                else a_valid = 1'b0;
            end
            d_ready = ($urandom % 4) != 0;
            cycle();
        end
        a_valid = 1'b0;
        d_ready = 1'b1;
        for (int k = 0; k < 4; k++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
